// File: rtl/encoder_8to3_req_if.sv
// Handshake/bus bundle for encoder_8to3_req: request capture inputs and
// the valid/ready code output towards the consumer.
interface encoder_8to3_req_if;
    logic       en;
    logic [7:0] req_n;
    logic       ready;
    logic       A;
    logic       B;
    logic       C;
    logic       valid;
    logic       any_pend;
    logic       ovf;

    modport master (
        output en, req_n, ready,
        input  A, B, C, valid, any_pend, ovf
    );

    modport slave (
        input  en, req_n, ready,
        output A, B, C, valid, any_pend, ovf
    );
endinterface

// File: rtl/encoder_8to3_req.sv
// Registered 8-to-3 request encoder with pending register and valid/ready output.
// Define ROUND_ROBIN_EN for rotating priority; default is fixed priority (bit 7 highest).
module encoder_8to3_req #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE        = 1
) (
    input logic               clk,
    input logic               rst,
    encoder_8to3_req_if.slave bus
);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state_q, state_d;
    logic [7:0] s;
    logic [7:0] prev_q;
    logic [7:0] pending_q;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic       ovf_q;
    logic [7:0] set;
    logic [7:0] clr;
    logic       handshake;
    logic       ovf_hit;
    logic [2:0] start;
    logic [2:0] sel_idx;
    logic [2:0] cand;
    logic       found;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = bus.req_n;
        end else begin : g_sync
            logic [7:0] sync_q [SYNC_STAGES];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
                end else begin
                    sync_q[0] <= bus.req_n;
                    for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // prev and the sync chain both reset to all-ones so release never looks like an edge
    always_ff @(posedge clk) begin
        if (rst) prev_q <= '1;
        else     prev_q <= s;
    end

`ifdef ROUND_ROBIN_EN
    logic [2:0] last_q;
    always_ff @(posedge clk) begin
        if (rst)            last_q <= '0;
        else if (handshake) last_q <= idx_q;
    end
    assign start = last_q - 3'd1;
`else
    assign start = 3'd7;
`endif

    assign handshake = valid_q & bus.ready;
    assign clr       = handshake ? (8'b1 << idx_q) : '0;
    assign set       = bus.en ? ((EDGE != 0) ? (prev_q & ~s) : ~s) : '0;
    assign ovf_hit   = (EDGE != 0) && (|(set & pending_q & ~clr));

    // Descending search from start, wrapping 0 -> 7; the first hit wins
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            cand = start - 3'(k);
            if (!found && pending_q[cand]) begin
                sel_idx = cand;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    idx_d   = sel_idx;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= (pending_q & ~clr) | set;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_q | ovf_hit;
        end
    end

    assign bus.A        = idx_q[2];
    assign bus.B        = idx_q[1];
    assign bus.C        = idx_q[0];
    assign bus.valid    = valid_q;
    assign bus.any_pend = |pending_q;
    assign bus.ovf      = ovf_q;

endmodule
